cru_xfer_gen: RTL and testbench
===============================

Name: cru_xfer_gen

Overview:
- Parametrised CRU bit-serial transfer engine. Successor to the single-shot CRU read-cycle generator.
- Performs multi-bit STCR-style reads and LDCR-style writes of 1..MAX_BITS bits.
- Auto-increments the CRU bit address per bit and inserts a programmable number of wait states per bit.
- Sits between the CPU sequencer (req/done handshake) and the CRU bus (cru_addr, cruout, cruin, cruclk).

Parameters:
- MAX_BITS, 16, maximum bits per transfer; also width of wdata/rdata.
- ADDR_W, 12, CRU bit-address width (A3..A14).
- WAIT_STATES, 2, settle cycles per bit before the strobe/sample cycle; legal range 0..15.

Ports:
- phi2  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  start request; sampled only in IDLE.
- rw  input  1  1 = read (sample cruin), 0 = write (drive cruout, pulse cruclk); captured with req.
- base_addr  input  ADDR_W  first CRU bit address; captured with req.
- count  input  $clog2(MAX_BITS+1)  bits to transfer; 0 means MAX_BITS; values above MAX_BITS clamp to MAX_BITS; captured with req.
- wdata  input  MAX_BITS  write data, LSB sent first; captured with req.
- cruin  input  1  CRU serial input.
- cru_addr  output  ADDR_W  current CRU bit address.
- cruout  output  1  current write bit.
- cruclk  output  1  write strobe, one phi2 cycle per bit.
- busy  output  1  high from the cycle after req acceptance until done.
- done  output  1  one-cycle completion pulse.
- rdata  output  MAX_BITS  read result, LSB = first bit read; valid from done onward until the next accepted req.

Behaviour:
- Reset values: cru_addr=0, cruout=0, cruclk=0, busy=0, done=0, rdata=0, state=IDLE, counters=0.
- Reset mid-transfer aborts immediately. All outputs take reset values at the next edge. No done pulse.
- States:
  - IDLE: on req=1, capture rw/base_addr/count/wdata, set cru_addr=base_addr, clear rdata if rw=1, go to SETTLE (or STROBE if WAIT_STATES=0).
  - SETTLE: cru_addr stable; cruout = current wdata bit (forced 0 for reads). Stay WAIT_STATES cycles.
  - STROBE: one cycle.
    - Write: cruclk=1.
    - Read: cruin sampled at the end of this cycle into rdata[bit_index].
    - Then, if bit_index = effective_count-1, go to DONE. Otherwise increment bit_index and cru_addr, and go to SETTLE (or STROBE if WAIT_STATES=0).
  - DONE: done=1, busy=0, cruclk=0; next cycle go to IDLE.
- Per-bit time is WAIT_STATES+1 cycles. Let N be the effective count and E the edge that accepts req. Then done is high in cycle E + N*(WAIT_STATES+1) + 1. The earliest next req is accepted in the cycle after done.
- cruclk is only ever high in STROBE with rw=0. It is never high in two consecutive cycles when WAIT_STATES>0. With WAIT_STATES=0 it stays high for N consecutive cycles, one per bit.
- cru_addr wraps modulo 2^ADDR_W (0xFFF+1 -> 0x000).
- req while busy or in DONE is ignored, not queued.
- Read results: rdata bits at index >= N stay 0.
- cru_addr holds its last value after DONE until the next accepted req.

Optional Feature:
- Macro: CRU_ABORT_EN.
- Defined:
  - Adds input abort (1) and output aborted (1, reset 0).
  - abort=1 in SETTLE or STROBE sends the block to IDLE at that edge. busy=0 and cruclk=0 next cycle. No done pulse.
  - aborted pulses for one cycle.
  - rdata keeps the bits already sampled.
  - abort in IDLE or DONE has no effect.
- Undefined: ports absent; behaviour as above.

Test Plan:
- Write, WAIT_STATES=2, base_addr=0x020, count=4, wdata=0x000A -> cruclk pulses at cycles 3,6,9,12 after acceptance. cruout 0,1,0,1 during the pulses. cru_addr 0x020..0x023. done at cycle 13.
- Read, count=0 (16 bits), cruin pattern 0xA5C3 LSB first -> rdata=0xA5C3, done exactly 16*3+1 cycles after acceptance, cruclk never high.
- Read, count=3, cruin=1 always -> rdata=0x0007. Upper bits 0 even when the previous rdata was 0xFFFF.
- Wrap: base_addr=0xFFE, count=4 -> cru_addr sequence 0xFFE, 0xFFF, 0x000, 0x001.
- Reset asserted during bit 2 of an 8-bit write -> next cycle all outputs 0, no done. A fresh req is accepted immediately afterwards.
- req held high through a transfer -> exactly one transfer per done. With CRU_ABORT_EN, abort at bit 1 -> aborted pulse, no done, busy=0 next cycle.

Source files
------------

// File: rtl/cru_xfer_gen.sv
// ============================================================================
// cru_xfer_gen : multi-bit CRU read/write transfer engine with auto-increment
//                address and programmable per-bit wait states.
// Optional macro CRU_ABORT_EN adds abort_i / aborted_o.
// Revision 1.0
// ============================================================================
`default_nettype none

module cru_xfer_gen #(
  parameter int MAX_BITS    = 16,
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic                            phi2_i,
  input  logic                            reset_i,
  input  logic                            req_i,
  input  logic                            rw_i,
  input  logic [ADDR_W-1:0]               base_addr_i,
  input  logic [$clog2(MAX_BITS+1)-1:0]   count_i,
  input  logic [MAX_BITS-1:0]             wdata_i,
  input  logic                            cruin_i,
`ifdef CRU_ABORT_EN
  input  logic                            abort_i,
  output logic                            aborted_o,
`endif
  output logic [ADDR_W-1:0]               cru_addr_o,
  output logic                            cruout_o,
  output logic                            cruclk_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [MAX_BITS-1:0]             rdata_o
);

  localparam int CNT_W = $clog2(MAX_BITS + 1);
  localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BITS);
  localparam logic [3:0]       WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_STROBE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Every bit starts in SETTLE unless there are no wait states to spend there.
  localparam state_e S_FIRST = (WAIT_STATES == 0) ? S_STROBE : S_SETTLE;

  state_e              state_q, state_d;
  logic                rw_q, rw_d;
  logic [MAX_BITS-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]    bit_q, bit_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [3:0]          wait_q, wait_d;
  logic [MAX_BITS-1:0] rdata_q, rdata_d;
`ifdef CRU_ABORT_EN
  logic                aborted_q, aborted_d;
`endif

  logic [CNT_W-1:0]    eff_cnt;
  logic                active;

  assign eff_cnt = ((count_i == '0) || (count_i > MAX_CNT)) ? MAX_CNT : count_i;
  assign active  = (state_q == S_SETTLE) || (state_q == S_STROBE);

  always_ff @(posedge phi2_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      addr_q    <= '0;
      bit_q     <= '0;
      last_q    <= '0;
      wait_q    <= '0;
      rdata_q   <= '0;
`ifdef CRU_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      bit_q     <= bit_d;
      last_q    <= last_d;
      wait_q    <= wait_d;
      rdata_q   <= rdata_d;
`ifdef CRU_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    bit_d     = bit_q;
    last_d    = last_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
`ifdef CRU_ABORT_EN
    aborted_d = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          rw_d    = rw_i;
          wdata_d = wdata_i;
          addr_d  = base_addr_i;
          bit_d   = '0;
          last_d  = IDX_W'(eff_cnt - 1'b1);
          wait_d  = '0;
          if (rw_i) rdata_d = '0;
          state_d = S_FIRST;
        end
      end

      S_SETTLE: begin
        if (wait_q == WS_LAST) begin
          wait_d  = '0;
          state_d = S_STROBE;
        end else begin
          wait_d  = wait_q + 4'd1;
        end
      end

      S_STROBE: begin
        if (rw_q) rdata_d[bit_q] = cruin_i;
        if (bit_q == last_q) begin
          state_d = S_DONE;
        end else begin
          bit_d   = bit_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = S_FIRST;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

`ifdef CRU_ABORT_EN
    // Abort wins over the strobe: the in-flight bit is neither sampled nor advanced.
    if (abort_i && active) begin
      state_d   = S_IDLE;
      addr_d    = addr_q;
      bit_d     = bit_q;
      wait_d    = '0;
      rdata_d   = rdata_q;
      aborted_d = 1'b1;
    end
`endif
  end

  assign cru_addr_o = addr_q;
  assign cruout_o   = active && !rw_q && wdata_q[bit_q];
  assign cruclk_o   = (state_q == S_STROBE) && !rw_q;
  assign busy_o     = active;
  assign done_o     = (state_q == S_DONE);
  assign rdata_o    = rdata_q;
`ifdef CRU_ABORT_EN
  assign aborted_o  = aborted_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cru_xfer_gen.sv
// ============================================================================
// tb_cru_xfer_gen : randomized + directed bench for cru_xfer_gen against a
//                   cycle-count behavioural model. Revision 1.0
// ============================================================================
`default_nettype none

module tb_cru_xfer_gen;

  localparam int MAX_BITS = 16;
  localparam int ADDR_W   = 12;
  localparam int WS       = 2;
  localparam int CW       = $clog2(MAX_BITS + 1);
  localparam int PER      = WS + 1;
  localparam int BUDGET   = MAX_BITS * PER + 6;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req = 1'b0;
  logic                rw  = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [CW-1:0]       count = '0;
  logic [MAX_BITS-1:0] wdata = '0;
  logic                cruin;
  logic [ADDR_W-1:0]   cru_addr;
  logic                cruout, cruclk, busy, done;
  logic [MAX_BITS-1:0] rdata;
`ifdef CRU_ABORT_EN
  logic                abort = 1'b0;
  logic                aborted;
`endif

  // CRU device: one readable bit per address.
  logic cru_mem [0:(1<<ADDR_W)-1];
  assign cruin = cru_mem[cru_addr];

  int checks   = 0;
  int failures = 0;

  cru_xfer_gen #(.MAX_BITS(MAX_BITS), .ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .phi2_i      (clk),
    .reset_i     (rst),
    .req_i       (req),
    .rw_i        (rw),
    .base_addr_i (base_addr),
    .count_i     (count),
    .wdata_i     (wdata),
    .cruin_i     (cruin),
`ifdef CRU_ABORT_EN
    .abort_i     (abort),
    .aborted_o   (aborted),
`endif
    .cru_addr_o  (cru_addr),
    .cruout_o    (cruout),
    .cruclk_o    (cruclk),
    .busy_o      (busy),
    .done_o      (done),
    .rdata_o     (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: transfer = timeline of N*PER+1 cycles
  bit                  m_valid = 1'b0;
  bit                  m_active = 1'b0;
  int                  m_k = 0;
  int                  m_n = 0;
  logic                m_rw = 1'b0;
  logic [ADDR_W-1:0]   m_base = '0;
  logic [MAX_BITS-1:0] m_wdata = '0;
  logic [MAX_BITS-1:0] m_rdata = '0;
  logic [ADDR_W-1:0]   m_hold = '0;
  logic                m_aborted = 1'b0;

  function automatic int eff(input logic [CW-1:0] c);
    return (c == 0 || int'(c) > MAX_BITS) ? MAX_BITS : int'(c);
  endfunction

  always @(posedge clk) begin
    int tot;
    tot = m_n * PER;
    m_aborted <= 1'b0;
    if (rst) begin
      m_valid  <= 1'b1;
      m_active <= 1'b0;
      m_k      <= 0;
      m_rdata  <= '0;
      m_hold   <= '0;
    end else if (m_active) begin
      if (m_k == tot + 1) begin
        m_active <= 1'b0;
        m_hold   <= ADDR_W'(int'(m_base) + m_n - 1);
      end
`ifdef CRU_ABORT_EN
      else if (abort) begin
        m_active  <= 1'b0;
        m_aborted <= 1'b1;
        m_hold    <= ADDR_W'(int'(m_base) + (m_k - 1) / PER);
      end
`endif
      else begin
        if (m_rw && (m_k % PER) == 0) m_rdata[(m_k / PER) - 1] <= cruin;
        m_k <= m_k + 1;
      end
    end else if (req) begin
      m_active <= 1'b1;
      m_k      <= 1;
      m_rw     <= rw;
      m_base   <= base_addr;
      m_n      <= eff(count);
      m_wdata  <= wdata;
      if (rw) m_rdata <= '0;
    end
  end

  always @(negedge clk) begin
    int tot, bi, ph;
    logic [ADDR_W-1:0] e_addr;
    logic e_out, e_clk, e_busy, e_done;
    if (m_valid) begin
      tot = m_n * PER;
      if (!m_active) begin
        e_addr = m_hold; e_out = 1'b0; e_clk = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      end else if (m_k <= tot) begin
        bi = (m_k - 1) / PER;
        ph = (m_k - 1) % PER;
        e_addr = ADDR_W'(int'(m_base) + bi);
        e_out  = m_rw ? 1'b0 : m_wdata[bi];
        e_clk  = !m_rw && (ph == PER - 1);
        e_busy = 1'b1;
        e_done = 1'b0;
      end else begin
        e_addr = ADDR_W'(int'(m_base) + m_n - 1);
        e_out = 1'b0; e_clk = 1'b0; e_busy = 1'b0; e_done = 1'b1;
      end
      chk("cru_addr", 32'(cru_addr), 32'(e_addr));
      chk("cruout",   32'(cruout),   32'(e_out));
      chk("cruclk",   32'(cruclk),   32'(e_clk));
      chk("busy",     32'(busy),     32'(e_busy));
      chk("done",     32'(done),     32'(e_done));
      chk("rdata",    32'(rdata),    32'(m_rdata));
`ifdef CRU_ABORT_EN
      chk("aborted",  32'(aborted),  32'(m_aborted));
`endif
    end
  end

  // ---------------- directed/random driver
  int                q_clk[$];
  logic              q_out[$];
  logic [ADDR_W-1:0] q_addr[$];
  logic [ADDR_W-1:0] wrap_exp [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

  task automatic run_xfer(input logic r, input logic [ADDR_W-1:0] b, input logic [CW-1:0] c,
                          input logic [MAX_BITS-1:0] wd, input bit noise, output int dcyc);
    bit seen;
    @(negedge clk);
    req = 1'b1; rw = r; base_addr = b; count = c; wdata = wd;
    q_clk.delete(); q_out.delete(); q_addr.delete();
    seen = 1'b0;
    dcyc = -1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (cruclk) begin q_clk.push_back(k); q_out.push_back(cruout); end
      if ((k % PER) == 0 && busy) q_addr.push_back(cru_addr);
      if (done) begin
        seen = 1'b1; dcyc = k; req = 1'b0;
        break;
      end
      req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        rw = 1'($urandom); base_addr = ADDR_W'($urandom); count = CW'($urandom);
        wdata = MAX_BITS'($urandom);
      end
    end
    chk("xfer_completes", 32'(seen), 32'd1);
  endtask

  initial begin
    int d;
    int ndone;
    logic [MAX_BITS-1:0] pat;
    logic [3:0] wexp;

    for (int i = 0; i < (1 << ADDR_W); i++) cru_mem[i] = 1'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_addr",  32'(cru_addr), 32'd0);
    chk("rst_clk",   32'(cruclk),   32'd0);
    chk("rst_rdata", 32'(rdata),    32'd0);
    rst = 1'b0;

    // Write 4 bits of 0xA at 0x020.
    wexp = 4'b1010;
    run_xfer(1'b0, 12'h020, CW'(4), 16'h000A, 1'b0, d);
    chk("t1_done_cycle", 32'(d), 32'd13);
    chk("t1_pulses", 32'(q_clk.size()), 32'd4);
    for (int i = 0; i < 4 && i < q_clk.size(); i++) begin
      chk("t1_pulse_cycle", 32'(q_clk[i]), 32'(3 * (i + 1)));
      chk("t1_pulse_out",   32'(q_out[i]), 32'(wexp[i]));
    end
    for (int i = 0; i < 4 && i < q_addr.size(); i++)
      chk("t1_addr", 32'(q_addr[i]), 32'(12'h020 + i));

    // 16-bit read of 0xA5C3 at 0x100.
    pat = 16'hA5C3;
    for (int i = 0; i < 16; i++) cru_mem[12'h100 + i] = pat[i];
    run_xfer(1'b1, 12'h100, CW'(0), MAX_BITS'($urandom), 1'b0, d);
    chk("t2_done_cycle", 32'(d), 32'd49);
    chk("t2_rdata", 32'(rdata), 32'h0000A5C3);
    chk("t2_no_cruclk", 32'(q_clk.size()), 32'd0);

    // All-ones read, then a 3-bit read must clear the upper bits.
    for (int i = 0; i < 16; i++) cru_mem[12'h200 + i] = 1'b1;
    run_xfer(1'b1, 12'h200, CW'(16), '0, 1'b0, d);
    chk("t3_rdata_full", 32'(rdata), 32'h0000FFFF);
    run_xfer(1'b1, 12'h200, CW'(3), '0, 1'b0, d);
    chk("t3_rdata_3", 32'(rdata), 32'h00000007);
    chk("t3_done_cycle", 32'(d), 32'd10);

    // Address wrap.
    run_xfer(1'b0, 12'hFFE, CW'(4), MAX_BITS'($urandom), 1'b0, d);
    chk("t4_addrs", 32'(q_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < q_addr.size(); i++)
      chk("t4_addr", 32'(q_addr[i]), 32'(wrap_exp[i]));

    // Reset during bit 2 of an 8-bit write, then immediate fresh request.
    @(negedge clk);
    req = 1'b1; rw = 1'b0; base_addr = 12'h0A0; count = CW'(8); wdata = 16'hFFFF;
    @(negedge clk);
    req = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy",  32'(busy),     32'd0);
    chk("t5_done",  32'(done),     32'd0);
    chk("t5_addr",  32'(cru_addr), 32'd0);
    chk("t5_clk",   32'(cruclk),   32'd0);
    chk("t5_out",   32'(cruout),   32'd0);
    chk("t5_rdata", 32'(rdata),    32'd0);
    rst = 1'b0; req = 1'b1; base_addr = 12'h055; count = CW'(2);
    @(negedge clk);
    req = 1'b0;
    chk("t5_busy_again", 32'(busy),     32'd1);
    chk("t5_addr_again", 32'(cru_addr), 32'h055);
    d = 0;
    for (int k = 0; k < BUDGET && !done; k++) begin @(negedge clk); d++; end
    chk("t5_done_cycle", 32'(d + 1), 32'd7);

    // req held high: one transfer per done, period N*PER+2.
    @(negedge clk);
    @(negedge clk);
    req = 1'b1; rw = 1'b0; base_addr = 12'h300; count = CW'(2); wdata = MAX_BITS'($urandom);
    ndone = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    req = 1'b0;
    chk("t6_dones", 32'(ndone), 32'd3);
    repeat (2) @(negedge clk);

`ifdef CRU_ABORT_EN
    // Abort during bit 1 of a read keeps bit 0.
    @(negedge clk);
    req = 1'b1; rw = 1'b1; base_addr = 12'h400; count = CW'(4);
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t7_aborted", 32'(aborted), 32'd1);
    chk("t7_busy",    32'(busy),    32'd0);
    chk("t7_done",    32'(done),    32'd0);
    chk("t7_rdata",   32'(rdata),   32'(cru_mem[12'h400]));
    @(negedge clk);
    chk("t7_aborted_pulse", 32'(aborted), 32'd0);
`endif

    // Randomized transfers with req/inputs noise while busy.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < (1 << ADDR_W); i++) cru_mem[i] = 1'($urandom);
      run_xfer(1'($urandom), ADDR_W'($urandom), CW'($urandom), MAX_BITS'($urandom), 1'b1, d);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
